// File: rtl/riscv_core_icache_pkg.sv
// Shared types and address-split helpers for the N-way instruction cache.
// No logic here; latency and backpressure are defined by the modules that import it.
package riscv_core_icache_pkg;

    typedef enum logic {
        ST_LOOKUP = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    localparam int WORDS_PER_BLOCK = 8;

    function automatic int offset_w();
        return 5;
    endfunction

    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_sets);
        return addr_w - offset_w() - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/riscv_core_icache_way.sv
// One cache way: valid/tag/data arrays, a single write port and a combinational read/hit port.
// Read is same-cycle; writes and invalidate-all land on the next edge and cannot be refused.
module riscv_core_icache_way #(
    parameter int TAG_W   = 52,
    parameter int IDX_W   = 7,
    parameter int BLOCK_W = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_widx,
    input  logic [TAG_W-1:0]   i_wtag,
    input  logic [BLOCK_W-1:0] i_wblock,
    output logic               o_wvalid,
    input  logic [IDX_W-1:0]   i_ridx,
    input  logic [TAG_W-1:0]   i_rtag,
    output logic               o_hit,
    output logic [BLOCK_W-1:0] o_rblock
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [BLOCK_W-1:0] r_data [SETS];

    // Invalidate wins over a same-cycle write so a flushed refill never becomes visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wblock;
        end
    end

    assign o_wvalid = r_valid[i_widx];
    assign o_hit    = r_valid[i_ridx] && (r_tag[i_ridx] == i_rtag);
    assign o_rblock = r_data[i_ridx];

endmodule

// File: rtl/riscv_core_icache_nway.sv
// N-way set-associative I-cache: combinational hit path, blocking single-block refill.
// Hit returns in the same cycle; a miss stalls the core for memory latency + 1 cycles.
module riscv_core_icache_nway
    import riscv_core_icache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int NUM_WAYS        = 2,
    parameter int NUM_SETS        = 128
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
    input  logic                       i_req,
    input  logic                       i_flush,
    output logic                       o_stall,
    output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
    output logic [ADDR_WIDTH-1:0]      o_addr_from_control_to_axi,
    output logic                       o_mem_req,
    input  logic                       i_mem_done,
    input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi
);
    localparam int OFF_W  = offset_w();
    localparam int IDX_W  = index_w(NUM_SETS);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, NUM_SETS);
    localparam int PTR_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WSEL_W = $clog2(WORDS_PER_BLOCK);

    state_e                r_state;
    logic                  r_flush_pend;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_axi_addr;
    logic [IDX_W-1:0]      r_idx;
    logic [TAG_W-1:0]      r_tag;
    logic [PTR_W-1:0]      r_ptr [NUM_SETS];

    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [WSEL_W-1:0]         w_wsel;
    logic [NUM_WAYS-1:0]       w_hit;
    logic [NUM_WAYS-1:0]       w_wvalid;
    logic [NUM_WAYS-1:0]       w_we;
    logic [AXI_DATA_WIDTH-1:0] w_block [NUM_WAYS];
    logic [AXI_DATA_WIDTH-1:0] w_hit_block;
    logic                      w_any_hit;
    logic [PTR_W-1:0]          w_victim;
    logic [PTR_W-1:0]          w_ptr_next;
    logic                      w_found;
    logic                      w_refill_done;
    logic                      w_clr;
    logic                      w_unused;

    assign w_idx    = i_addr_from_core[OFF_W +: IDX_W];
    assign w_tag    = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
    assign w_wsel   = i_addr_from_core[OFF_W-1:2];
    assign w_unused = ^i_addr_from_core[1:0];

    assign w_refill_done = (r_state == ST_REFILL) && i_mem_done;
    assign w_clr = ((r_state == ST_LOOKUP) && i_flush)
                || (w_refill_done && (r_flush_pend || i_flush));

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        assign w_we[g] = w_refill_done && (w_victim == PTR_W'(g));
        riscv_core_icache_way #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .BLOCK_W(AXI_DATA_WIDTH)
        ) u_way (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (w_clr),
            .i_we    (w_we[g]),
            .i_widx  (r_idx),
            .i_wtag  (r_tag),
            .i_wblock(i_block_from_axi),
            .o_wvalid(w_wvalid[g]),
            .i_ridx  (w_idx),
            .i_rtag  (w_tag),
            .o_hit   (w_hit[g]),
            .o_rblock(w_block[g])
        );
    end

    // Descending scan so the lowest-numbered matching way is the one left selected.
    always_comb begin
        w_any_hit   = 1'b0;
        w_hit_block = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_hit[w]) begin
                w_any_hit   = 1'b1;
                w_hit_block = w_block[w];
            end
        end
    end

    always_comb begin
        w_victim = r_ptr[r_idx];
        w_found  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_found && !w_wvalid[w]) begin
                w_victim = PTR_W'(w);
                w_found  = 1'b1;
            end
        end
    end

    assign w_ptr_next = (r_ptr[r_idx] == PTR_W'(NUM_WAYS - 1)) ? '0 : r_ptr[r_idx] + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) r_ptr[s] <= '0;
        end else if (w_clr) begin
            for (int s = 0; s < NUM_SETS; s++) r_ptr[s] <= '0;
        end else if (w_refill_done) begin
            r_ptr[r_idx] <= w_ptr_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_LOOKUP;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_axi_addr   <= '0;
            r_idx        <= '0;
            r_tag        <= '0;
        end else begin
            case (r_state)
                ST_LOOKUP: begin
                    if (i_req && !i_flush && !w_any_hit) begin
                        r_state    <= ST_REFILL;
                        r_idx      <= w_idx;
                        r_tag      <= w_tag;
                        r_mem_req  <= 1'b1;
                        r_axi_addr <= {i_addr_from_core[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (i_flush) r_flush_pend <= 1'b1;
                    if (i_mem_done) begin
                        r_state      <= ST_LOOKUP;
                        r_mem_req    <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: r_state <= ST_LOOKUP;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted, even with a fetch presented.
    always_comb begin
        o_stall        = 1'b0;
        o_data_to_core = '0;
        if (i_rst_n && i_req) begin
            if ((r_state == ST_REFILL) || i_flush || !w_any_hit) begin
                o_stall = 1'b1;
            end else begin
                o_data_to_core = w_hit_block[w_wsel*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
            end
        end
    end

    assign o_mem_req                  = r_mem_req;
    assign o_addr_from_control_to_axi = r_axi_addr;

endmodule

// File: tb/tb_riscv_core_icache_nway.sv
// Bench for riscv_core_icache_nway: directed fetches, modelled refill memory, scoreboard monitor.
// Expected words, refill addresses and stall counts are queued by the driver and popped by the monitor.
module tb_riscv_core_icache_nway;

    localparam int LAT = 5;

    logic         clk;
    logic         rst_n;
    logic [63:0]  addr;
    logic         req;
    logic         flush;
    logic         o_stall;
    logic [31:0]  o_data;
    logic [63:0]  o_axi_addr;
    logic         o_mem_req;
    logic         mem_done;
    logic [255:0] blk;

    int errors = 0;
    int checks = 0;

    logic [63:0] fq_addr [$];
    logic [31:0] fq_data [$];
    int          fq_stall[$];
    logic [63:0] rq      [$];

    riscv_core_icache_nway dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_addr_from_core          (addr),
        .i_req                     (req),
        .i_flush                   (flush),
        .o_stall                   (o_stall),
        .o_data_to_core            (o_data),
        .o_addr_from_control_to_axi(o_axi_addr),
        .o_mem_req                 (o_mem_req),
        .i_mem_done                (mem_done),
        .i_block_from_axi          (blk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] gen_block(input logic [63:0] base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k*32 +: 32] = {base[15:0], 8'hC0, 8'(k)};
        end
        if (base == 64'h1000) b[63:32] = 32'hDEADBEEF;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: sees o_mem_req, answers LAT cycles later with a one-cycle done strobe.
    initial begin
        logic [63:0] base;
        mem_done = 1'b0;
        blk      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (o_mem_req) begin
                base = o_axi_addr;
                repeat (LAT - 1) @(posedge clk);
                #1;
                mem_done = 1'b1;
                blk      = gen_block(base);
                @(posedge clk);
                #1;
                mem_done = 1'b0;
                blk      = '0;
            end
        end
    end

    // Monitor: refill address on each o_mem_req rise, word/stall count/o_mem_req on each completion.
    initial begin
        logic mem_req_q;
        int   stall_cnt;
        mem_req_q = 1'b0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
            end else begin
                if (o_mem_req && !mem_req_q) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL refill_unexpected: got addr 0x%0h, expected no refill", o_axi_addr);
                    end else begin
                        check("refill_addr", o_axi_addr, rq.pop_front());
                    end
                end
                if (req && o_stall) stall_cnt++;
                if (req && !o_stall) begin
                    if (fq_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected: got data 0x%0h, expected none", o_data);
                    end else begin
                        logic [63:0] a;
                        int          es;
                        a  = fq_addr.pop_front();
                        es = fq_stall.pop_front();
                        check($sformatf("data@%0h", a), 64'(o_data), 64'(fq_data.pop_front()));
                        check($sformatf("stalls@%0h", a), 64'(stall_cnt), 64'(es));
                        check($sformatf("memreq_on_hit@%0h", a), 64'(o_mem_req), 64'd0);
                    end
                    stall_cnt = 0;
                end
            end
            mem_req_q = o_mem_req;
        end
    end

    // One fetch; n_miss refills expected for its block, optional flush pulse at stall cycle flush_at.
    task automatic fetch(input logic [63:0] a, input logic [31:0] exp, input int n_miss,
                         input int exp_stalls, input int flush_at);
        bit done;
        done = 1'b0;
        fq_addr.push_back(a);
        fq_data.push_back(exp);
        fq_stall.push_back(exp_stalls);
        for (int m = 0; m < n_miss; m++) rq.push_back({a[63:5], 5'b0});
        @(posedge clk);
        #1;
        addr = a;
        req  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            flush = 1'b0;
            if (!o_stall) begin
                done = 1'b1;
                break;
            end
            if (c == flush_at) flush = 1'b1;
        end
        flush = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout@%0h: o_stall still 1, expected 0 within 60 cycles", a);
            void'(fq_addr.pop_back());
            void'(fq_data.pop_back());
            void'(fq_stall.pop_back());
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        req   = 1'b1;
        addr  = 64'h1004;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_mem_req", 64'(o_mem_req), 64'd0);
        check("rst_axi_addr", o_axi_addr, 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fetch(64'h1004, 32'hDEADBEEF, 1, LAT + 1, -1);
        fetch(64'h101C, 32'h1000C007, 0, 0, -1);
        fetch(64'h2000, 32'h2000C000, 1, LAT + 1, -1);
        fetch(64'h1000, 32'h1000C000, 0, 0, -1);
        fetch(64'h3008, 32'h3000C002, 1, LAT + 1, -1);
        fetch(64'h2004, 32'h2000C001, 0, 0, -1);
        fetch(64'h1000, 32'h1000C000, 1, LAT + 1, -1);
        fetch(64'h300C, 32'h3000C003, 0, 0, -1);

        @(negedge clk);
        addr = 64'h3000;
        #1;
        check("idle_stall", 64'(o_stall), 64'd0);
        check("idle_data", 64'(o_data), 64'd0);

        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fetch(64'h1000, 32'h1000C000, 1, LAT + 1, -1);

        fetch(64'h5024, 32'h5020C001, 2, 2 * (LAT + 1), 2);
        fetch(64'h5020, 32'h5020C000, 0, 0, -1);

        rq.push_back(64'h6000);
        @(negedge clk);
        addr = 64'h6000;
        req  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrefill_req_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 64'(o_mem_req), 64'd0);
        check("midrst_axi_addr", o_axi_addr, 64'd0);
        check("midrst_stall", 64'(o_stall), 64'd0);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("late_done_mem_req", 64'(o_mem_req), 64'd0);

        fetch(64'h6004, 32'h6000C001, 1, LAT + 1, -1);
        fetch(64'h1000, 32'h1000C000, 1, LAT + 1, -1);

        repeat (3) @(negedge clk);
        check("fetch_queue_empty", 64'(fq_data.size()), 64'd0);
        check("refill_queue_empty", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
